strobe_period_monitor: RTL
==========================

Name: strobe_period_monitor

Overview:
- Receiver-side checker for periodic single-cycle enable strobes, such as the divide-by-N `clk_flag` pulses produced by the team's clock dividers.
- Measures the interval between strobe rising edges in `sys_clk` cycles.
- Declares lock after a run of identical intervals.
- Flags and counts period errors and strobe loss.
- Sits downstream of any divider/flag generator as a self-check and debug monitor.

Parameters:
- CNT_W, 8, width of the period counter and of the `period` output; maximum measurable period 2^CNT_W-1.
- LOCK_CNT, 4, number of consecutive equal periods required to enter LOCKED (legal range 2..15).
- EXP_PERIOD, 6, expected period in cycles; used only when EXP_PERIOD_CHECK_EN is defined.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge
- sys_rst_n  input  1  reset, synchronous, active-low
- clk_flag  input  1  strobe under test, synchronous to sys_clk
- period  output  CNT_W  last measured period in cycles
- period_valid  output  1  one-cycle pulse: `period` updated
- locked  output  1  high while in LOCKED state
- err_pulse  output  1  one-cycle pulse on period mismatch or timeout while locked
- err_cnt  output  8  saturating count of err_pulse events

Behaviour:
- Reset:
  - Reset is synchronous, active-low: sampled only on the rising edge of `sys_clk`.
  - While `sys_rst_n`=0 at a clock edge: state=IDLE, period=0, period_valid=0, locked=0, err_pulse=0, err_cnt=0, and all internal counters and flag history are cleared.
  - Reset asserted mid-measurement discards all history. The first edge after reset is treated as a fresh reference.
- Edge detect:
  - Register `flag_d`; edge = clk_flag & ~flag_d.
  - A strobe held high for several cycles counts as one event.
- Interval counter `cnt` (CNT_W bits):
  - On an edge, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 2^CNT_W-1.
  - The measured period is the value of `cnt` in the edge cycle. For edges 6 cycles apart, the measured period is 6.
- State IDLE (no reference edge):
  - On edge: go to ACQ, match=0. No measurement is made.
- State ACQ:
  - On edge: period <= cnt and period_valid=1 on the next cycle.
  - If match=0 or cnt != last: last <= cnt, match <= 1.
  - Otherwise: match <= match+1.
  - When the updated match equals LOCK_CNT: go to LOCKED and set locked=1 in the same registered update.
  - Timeout (cnt saturated with no edge): go to IDLE silently, no error.
- State LOCKED:
  - On edge: period and period_valid update as in ACQ.
  - If cnt != last: err_pulse=1, err_cnt increments, locked=0, state=ACQ, last <= cnt, match <= 1.
  - Timeout: err_pulse=1, err_cnt increments, locked=0, state=IDLE.
- Timing: all outputs are registered. period_valid and err_pulse assert exactly 1 cycle after the sampling edge at which the strobe rising edge is detected, and last 1 cycle.
- Simultaneous events: an edge in the same cycle cnt reaches saturation is treated as a valid edge with period = 2^CNT_W-1. No timeout is raised.
- err_cnt saturates at 255 and holds.
- locked never asserts with fewer than LOCK_CNT measured periods since the last reset, timeout or mismatch.

Optional Feature:
- Macro: EXP_PERIOD_CHECK_EN.
- Defined:
  - In ACQ, a measured period != EXP_PERIOD sets match <= 0, so lock is reached only on EXP_PERIOD.
  - In LOCKED, a period != EXP_PERIOD raises err_pulse and returns to ACQ.
- Undefined: the block locks on any stable period, and EXP_PERIOD is unused.

Test Plan:
- Edges every 6 cycles from reset release (LOCK_CNT=4) -> first period_valid at edge 2 with period=6; locked=1 after edge 5; err_cnt=0.
- Locked at period 6, then one interval of 5 cycles -> err_pulse once, err_cnt=1, locked=0, period=5; locked again after 4 further equal intervals.
- Locked, then clk_flag held low for 300 cycles (CNT_W=8) -> err_pulse once at cnt=255, state IDLE, locked=0; the next edge produces no period_valid.
- clk_flag held high for 3 cycles every 6 cycles -> treated as single edges, period=6, lock achieved, no errors.
- Assert sys_rst_n=0 for 1 cycle while locked -> all outputs 0 on the next cycle; re-lock takes 5 edges.
- With EXP_PERIOD_CHECK_EN and EXP_PERIOD=6, stimulus with edges every 7 cycles -> period_valid with period=7 each edge; locked stays 0; err_cnt stays 0.

Source files
------------

// File: rtl/strobe_period_monitor.sv
// -----------------------------------------------------------------------------
// strobe_period_monitor
//
// Receiver-side checker for periodic single-cycle enable strobes (for example
// the divide-by-N clk_flag pulses of a clock divider). It measures the number
// of sys_clk cycles between strobe rising edges, declares lock after LOCK_CNT
// identical intervals, and flags/counts period mismatches and strobe loss.
//
// Optional feature macro: EXP_PERIOD_CHECK_EN
//   defined   : lock is only reached on EXP_PERIOD; any other period while
//               locked is an error.
//   undefined : lock on any stable period; EXP_PERIOD has no effect.
//
// Ports:
//   sys_clk      in   system clock, all logic on its rising edge
//   sys_rst_n    in   synchronous active-low reset
//   clk_flag     in   strobe under test, synchronous to sys_clk
//   period       out  last measured period in cycles (CNT_W bits)
//   period_valid out  one-cycle pulse when period is updated
//   locked       out  high while in the LOCKED state
//   err_pulse    out  one-cycle pulse on mismatch or timeout while locked
//   err_cnt      out  saturating count of err_pulse events (8 bits)
// -----------------------------------------------------------------------------
module strobe_period_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_CNT   = 4,
    parameter int EXP_PERIOD = 6
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_flag,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [7:0]       err_cnt
);

`ifdef EXP_PERIOD_CHECK_EN
    localparam bit EXP_CHECK_ON = 1'b1;
`else
    localparam bit EXP_CHECK_ON = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_VAL = CNT_W'(EXP_PERIOD);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // no reference edge yet
        ACQ    = 2'd1,  // collecting equal intervals
        LOCKED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             flag_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [3:0]       match_q, match_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic strobe_edge;
    logic timeout;
    logic exp_ok;
    logic err_event;

    // A strobe held high for several cycles yields a single event.
    assign strobe_edge = clk_flag & ~flag_q;
    // An edge coinciding with saturation is a valid 2^CNT_W-1 period, not a loss.
    assign timeout     = (cnt_q == CNT_MAX) & ~strobe_edge;
    assign exp_ok      = !EXP_CHECK_ON || (cnt_q == EXP_VAL);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        last_d         = last_q;
        match_d        = match_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_pulse_d    = 1'b0;
        err_cnt_d      = err_cnt_q;
        err_event      = 1'b0;

        if (strobe_edge) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        unique case (state_q)
            IDLE: begin
                // First edge is only a reference; nothing is measured yet.
                if (strobe_edge) begin
                    state_d = ACQ;
                    match_d = 4'd0;
                end
            end

            ACQ: begin
                if (strobe_edge) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    if (match_q == 4'd0 || cnt_q != last_q) begin
                        last_d  = cnt_q;
                        match_d = 4'd1;
                    end else begin
                        match_d = match_q + 4'd1;
                    end
                    if (!exp_ok) begin
                        match_d = 4'd0;
                    end
                    if (match_d == LOCK_N) begin
                        state_d = LOCKED;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end

            LOCKED: begin
                if (strobe_edge) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    if (cnt_q != last_q || !exp_ok) begin
                        err_event = 1'b1;
                        state_d   = ACQ;
                        last_d    = cnt_q;
                        match_d   = exp_ok ? 4'd1 : 4'd0;
                    end
                end else if (timeout) begin
                    err_event = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_event) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        // locked is registered together with the state it reflects.
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            flag_q         <= 1'b0;
            cnt_q          <= '0;
            last_q         <= '0;
            match_q        <= 4'd0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_cnt_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            flag_q         <= clk_flag;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
            match_q        <= match_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_pulse_q    <= err_pulse_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err_pulse    = err_pulse_q;
    assign err_cnt      = err_cnt_q;

endmodule
